// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
//   Shared types and defaults for the fifo1 read-side controller.
//   state_t : controller FSM states (IDLE, DRAIN, FLUSH)
//   DSIZE_DEF / CNTW_DEF : default data and burst-count widths
//   ERRW : width of the optional sequence-checker error counter
//   (the checker is built only when FIFO_RD_CHECK_EN is defined)
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DSIZE_DEF = 8;
  localparam int CNTW_DEF  = 8;
  localparam int ERRW      = 8;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid
//   Two-entry valid/ready buffer sitting between the fifo1 pop strobe and
//   the downstream stream.
//   Handshake: a word moves downstream on any rising clk where
//   m_valid & m_ready; m_data is held stable while m_valid & !m_ready.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     push        capture push_data this cycle (caller guarantees cnt<2 or a pop)
//     push_data   word to capture
//     cnt         number of held words (0..2), registered
//     m_valid     head entry is valid
//     m_data      head entry
//     m_ready     downstream accepts the head entry
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  output logic [1:0]       cnt,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready
);

  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] tail_q;
  logic [1:0]       cnt_q;
  logic             pop;

  assign pop     = (cnt_q != 2'd0) && m_ready;
  assign cnt     = cnt_q;
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = head_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_q <= push_data;
            cnt_q  <= 2'd1;
          end else if (cnt_q == 2'd1) begin
            tail_q <= push_data;
            cnt_q  <= 2'd2;
          end
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new word lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
//   Read-side controller for the fifo1 async FIFO (rclk domain). A start
//   drains burst_len words from fifo1 into a 2-entry skid buffer, which
//   presents them on a valid/ready stream; done pulses once every word has
//   been handed downstream.
//   Optional feature macro: FIFO_RD_CHECK_EN adds an incrementing-sequence
//   checker with ports seq_err and err_cnt.
//   Ports:
//     rclk, rrst_n      clock, synchronous active-low reset
//     rdata, rempty     fifo1 read data / empty flag
//     rinc              pop strobe to fifo1
//     start, burst_len  burst request (honoured in IDLE only) and word count
//     busy, done        burst in progress / 1-cycle completion pulse
//     m_valid, m_data, m_ready  downstream stream
//     seq_err, err_cnt  sticky mismatch flag and saturating count (checker only)
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int CNTW  = CNTW_DEF
`ifdef FIFO_RD_CHECK_EN
  , parameter int CHK_SEED = 1
`endif
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             start,
  input  logic [CNTW-1:0]  burst_len,
  output logic             busy,
  output logic             done,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready
`ifdef FIFO_RD_CHECK_EN
  , output logic            seq_err,
  output logic [ERRW-1:0]  err_cnt
`endif
);

  state_t          state_q;
  state_t          state_d;
  logic [CNTW-1:0] remaining_q;
  logic            done_q;
  logic            done_d;
  logic            rinc_c;
  logic            start_ok;
  logic [1:0]      skid_cnt;
  logic            skid_pop;

  assign start_ok = (state_q == IDLE) && start && (burst_len != '0);
  assign skid_pop = m_valid && m_ready;

  // rinc depends on registered state only, so m_ready never reaches it
  // combinationally.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    rinc_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) state_d = DRAIN;
          else                 done_d  = 1'b1;
        end
      end
      DRAIN: begin
        rinc_c = !rempty && (skid_cnt != 2'd2) && (remaining_q != '0);
        if (rinc_c && (remaining_q == CNTW'(1))) state_d = FLUSH;
      end
      FLUSH: begin
        // Leave as soon as the last held word is handed off, even when
        // that handoff happens this very cycle.
        if ((skid_cnt == 2'd0) || ((skid_cnt == 2'd1) && skid_pop)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_ok)    remaining_q <= burst_len;
      else if (rinc_c) remaining_q <= remaining_q - CNTW'(1);
    end
  end

  assign rinc = rinc_c;
  assign busy = (state_q != IDLE);
  assign done = done_q;

  fifo_rd_skid #(
    .DSIZE (DSIZE)
  ) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (rinc_c),
    .push_data (rdata),
    .cnt       (skid_cnt),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
  );

`ifdef FIFO_RD_CHECK_EN
  logic [DSIZE-1:0] expected_q;
  logic             seq_err_q;
  logic [ERRW-1:0]  err_cnt_q;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      expected_q <= '0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else if (start_ok) begin
      expected_q <= DSIZE'(CHK_SEED);
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else if (rinc_c) begin
      expected_q <= expected_q + DSIZE'(1);
      if (rdata != expected_q) begin
        seq_err_q <= 1'b1;
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERRW'(1);
      end
    end
  end

  assign seq_err = seq_err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl
//   Directed bench for fifo_rd_ctrl. A queue models fifo1 (pop on rinc,
//   rempty/rdata refreshed just after each rising edge); a scoreboard
//   compares every downstream transfer against an expected queue.
//   Define FIFO_RD_CHECK_EN to also exercise the sequence checker.
module tb_fifo_rd_ctrl;
  import fifo_rd_pkg::*;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          rclk;
  logic          rrst_n;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic          rinc;
  logic          start;
  logic [CW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
`ifdef FIFO_RD_CHECK_EN
  logic          seq_err;
  logic [7:0]    err_cnt;
`endif

  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  bit            pop_now;
  bit            underflow_seen = 0;

  fifo_rd_ctrl dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
`ifdef FIFO_RD_CHECK_EN
    , .seq_err (seq_err),
    .err_cnt   (err_cnt)
`endif
  );

  // clock / reset
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  // fifo1 model
  initial begin
    rempty = 1'b1;
    rdata  = '0;
  end

  always @(posedge rclk) begin
    pop_now = rinc;
    #1;
    if (pop_now && fq.size() != 0) void'(fq.pop_front());
    rempty = (fq.size() == 0);
    rdata  = rempty ? '0 : fq[0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard and underflow monitor, sampled mid-cycle
  always @(negedge rclk) begin
    if (rinc && rempty) underflow_seen = 1;
    if (rrst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) check("xfer_unexpected", 32'(m_data), 32'hffff_ffff);
      else check("xfer_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  task automatic load(input logic [DW-1:0] w, input bit expect_out);
    fq.push_back(w);
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (done) seen = 1;
    end
    check(tag, 32'(seen), 1);
  endtask

  initial begin
    rrst_n    = 1'b0;
    start     = 1'b0;
    burst_len = '0;
    m_ready   = 1'b1;
    step();
    step();
    check("rst_rinc", 32'(rinc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
`ifdef FIFO_RD_CHECK_EN
    check("rst_seq_err", 32'(seq_err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
`endif
    rrst_n = 1'b1;

    // 1) five words, m_ready held high
    for (int i = 1; i <= 5; i++) load(DW'(i), 1);
    step();
    start = 1'b1; burst_len = 8'd5;
    step();
    start = 1'b0;
    check("t1_busy", 32'(busy), 1);
    check("t1_rinc_first", 32'(rinc), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_m_data", 32'(m_data), 32'(i + 1));
      check("t1_m_valid", 32'(m_valid), 1);
      check("t1_rinc", 32'(rinc), 1);
    end
    step();
    check("t1_m_data_last", 32'(m_data), 5);
    check("t1_rinc_off", 32'(rinc), 0);
    step();
    check("t1_done", 32'(done), 1);
    check("t1_busy_off", 32'(busy), 0);
    step();
    check("t1_done_pulse", 32'(done), 0);

    // 2) downstream stalls for three cycles after the first word
    for (int i = 1; i <= 5; i++) load(DW'(i), 1);
    step();
    start = 1'b1; burst_len = 8'd5;
    step();
    start = 1'b0;
    step();
    check("t2_first", 32'(m_data), 1);
    m_ready = 1'b0;
    step();
    check("t2_rinc_full", 32'(rinc), 0);
    check("t2_hold_a", 32'(m_data), 1);
    step();
    check("t2_hold_b", 32'(m_data), 1);
    check("t2_rinc_full_b", 32'(rinc), 0);
    step();
    check("t2_hold_c", 32'(m_data), 1);
    m_ready = 1'b1;
    step();
    check("t2_next", 32'(m_data), 2);
    check("t2_rinc_resume", 32'(rinc), 1);
    wait_done("t2_done");
    check("t2_all_delivered", 32'(exp_q.size()), 0);

    // 3) fifo1 runs empty mid-burst
    load(8'h11, 1); load(8'h12, 1);
    step();
    start = 1'b1; burst_len = 8'd4;
    step();
    start = 1'b0;
    step();
    step();
    check("t3_stall_rinc", 32'(rinc), 0);
    check("t3_stall_busy", 32'(busy), 1);
    step();
    check("t3_stall_rinc_b", 32'(rinc), 0);
    check("t3_stall_busy_b", 32'(busy), 1);
    load(8'h13, 1); load(8'h14, 1);
    step();
    check("t3_resume", 32'(rinc), 1);
    wait_done("t3_done");
    check("t3_all_delivered", 32'(exp_q.size()), 0);

    // 4a) zero-length burst
    start = 1'b1; burst_len = 8'd0;
    step();
    start = 1'b0;
    check("t4_zero_done", 32'(done), 1);
    check("t4_zero_busy", 32'(busy), 0);
    check("t4_zero_rinc", 32'(rinc), 0);
    step();
    check("t4_zero_done_pulse", 32'(done), 0);
    check("t4_zero_rinc_b", 32'(rinc), 0);

    // 4b) start during DRAIN is ignored
    for (int i = 0; i < 5; i++) load(DW'(8'h21 + i), i < 3);
    step();
    start = 1'b1; burst_len = 8'd3;
    step();
    burst_len = 8'd8;
    step();
    start = 1'b0;
    wait_done("t4_done");
    check("t4_left_in_fifo", 32'(fq.size()), 2);
    fq.delete();
    step();

    // 5) reset after two words are popped
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) load(DW'(i), 0);
    step();
    start = 1'b1; burst_len = 8'd5;
    step();
    start = 1'b0;
    step();
    step();
    check("t5_two_popped", 32'(fq.size()), 3);
    rrst_n = 1'b0;
    step();
    check("t5_rst_rinc", 32'(rinc), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_done", 32'(done), 0);
    check("t5_rst_m_valid", 32'(m_valid), 0);
    check("t5_rst_m_data", 32'(m_data), 0);
    rrst_n = 1'b1;
    step();
    check("t5_no_done", 32'(done), 0);
    m_ready = 1'b1;
    for (int i = 3; i <= 5; i++) exp_q.push_back(DW'(i));
    start = 1'b1; burst_len = 8'd3;
    step();
    start = 1'b0;
    wait_done("t5_done");
    check("t5_all_delivered", 32'(exp_q.size()), 0);

`ifdef FIFO_RD_CHECK_EN
    // 6) sequence checker with one bad word
    load(8'h01, 1); load(8'h02, 1); load(8'h07, 1); load(8'h04, 1);
    step();
    start = 1'b1; burst_len = 8'd4;
    step();
    start = 1'b0;
    check("t6_cleared_err", 32'(seq_err), 0);
    check("t6_cleared_cnt", 32'(err_cnt), 0);
    step();
    step();
    check("t6_ok_two", 32'(seq_err), 0);
    step();
    check("t6_err_third", 32'(seq_err), 1);
    check("t6_cnt_third", 32'(err_cnt), 1);
    wait_done("t6_done");
    check("t6_err_final", 32'(seq_err), 1);
    check("t6_cnt_final", 32'(err_cnt), 1);
`endif

    step();
    check("no_underflow", 32'(underflow_seen), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
